// File: rtl/sargantana_idata_fill_memory.sv
// Instruction-cache data array with a beat-wise line refill engine.
// Reads are one-cycle registered per way; a completed refill is written in a single WRITE cycle.
module sargantana_idata_fill_memory #(
  parameter int unsigned ICACHE_N_WAY = 4,
  parameter int unsigned SET_WIDHT    = 256,
  parameter int unsigned ADDR_WIDHT   = 6,
  parameter int unsigned BEAT_WIDTH   = 64
) (
  input  logic                                     clk_i,
  input  logic                                     rstn_i,
  input  logic [ICACHE_N_WAY-1:0]                  rd_req_i,
  input  logic [ADDR_WIDHT-1:0]                    rd_addr_i,
  output logic                                     rd_valid_o,
  output logic [ICACHE_N_WAY-1:0][SET_WIDHT-1:0]   rd_data_way_o,
  input  logic                                     fill_start_i,
  input  logic [$clog2(ICACHE_N_WAY)-1:0]          fill_way_i,
  input  logic [ADDR_WIDHT-1:0]                    fill_addr_i,
  input  logic                                     fill_beat_valid_i,
  input  logic [BEAT_WIDTH-1:0]                    fill_beat_i,
  output logic                                     fill_beat_ready_o,
  input  logic                                     fill_abort_i,
  output logic                                     fill_busy_o,
  output logic                                     fill_done_o
);

  localparam int unsigned NBEATS = SET_WIDHT / BEAT_WIDTH;
  localparam int unsigned CNT_W  = $clog2(NBEATS);
  localparam int unsigned WAY_W  = $clog2(ICACHE_N_WAY);
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDHT;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } state_e;

  state_e                                 state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [WAY_W-1:0]                       way_q, way_d;
  logic [ADDR_WIDHT-1:0]                  addr_q, addr_d;
  logic                                   beat_acc;
  logic [SET_WIDHT-1:0]                   line_q;
  logic [SET_WIDHT-1:0]                   mem_q [ICACHE_N_WAY][DEPTH];
  logic                                   rd_valid_q, rd_valid_d;
  logic [ICACHE_N_WAY-1:0][SET_WIDHT-1:0] rd_data_q, rd_data_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    way_d    = way_q;
    addr_d   = addr_q;
    beat_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start_i) begin
          way_d   = fill_way_i;
          addr_d  = fill_addr_i;
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // Abort wins over a beat offered in the same cycle, so that beat is dropped.
        if (fill_abort_i) begin
          state_d = IDLE;
        end else if (fill_beat_valid_i) begin
          beat_acc = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      way_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
      addr_q  <= addr_d;
    end
  end

  // Line buffer and array carry no reset; the array only changes in WRITE.
  always_ff @(posedge clk_i) begin
    if (beat_acc) begin
      line_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= fill_beat_i;
    end
    if (state_q == WRITE) begin
      mem_q[way_q][addr_q] <= line_q;
    end
  end

  always_comb begin
    rd_valid_d = |rd_req_i;
    rd_data_d  = rd_data_q;
    for (int unsigned i = 0; i < ICACHE_N_WAY; i++) begin
      if (rd_req_i[i]) begin
        // Write-first bypass for a read hitting the line being written this cycle.
        if (state_q == WRITE && way_q == WAY_W'(i) && addr_q == rd_addr_i) begin
          rd_data_d[i] = line_q;
        end else begin
          rd_data_d[i] = mem_q[i][rd_addr_i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o        = rd_valid_q;
  assign rd_data_way_o     = rd_data_q;
  assign fill_beat_ready_o = (state_q == COLLECT);
  assign fill_busy_o       = (state_q != IDLE);
  assign fill_done_o       = (state_q == WRITE);

endmodule

// File: tb/tb_sargantana_idata_fill_memory.sv
// Directed bench for sargantana_idata_fill_memory: reference line model plus a
// read scoreboard queue checked one cycle after each read request.
module tb_sargantana_idata_fill_memory;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic [3:0]           rd_req_i;
  logic [5:0]           rd_addr_i;
  logic                 rd_valid_o;
  logic [3:0][255:0]    rd_data_way_o;
  logic                 fill_start_i;
  logic [1:0]           fill_way_i;
  logic [5:0]           fill_addr_i;
  logic                 fill_beat_valid_i;
  logic [63:0]          fill_beat_i;
  logic                 fill_beat_ready_o;
  logic                 fill_abort_i;
  logic                 fill_busy_o;
  logic                 fill_done_o;

  sargantana_idata_fill_memory #(
    .ICACHE_N_WAY(4),
    .SET_WIDHT   (256),
    .ADDR_WIDHT  (6),
    .BEAT_WIDTH  (64)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .rd_req_i         (rd_req_i),
    .rd_addr_i        (rd_addr_i),
    .rd_valid_o       (rd_valid_o),
    .rd_data_way_o    (rd_data_way_o),
    .fill_start_i     (fill_start_i),
    .fill_way_i       (fill_way_i),
    .fill_addr_i      (fill_addr_i),
    .fill_beat_valid_i(fill_beat_valid_i),
    .fill_beat_i      (fill_beat_i),
    .fill_beat_ready_o(fill_beat_ready_o),
    .fill_abort_i     (fill_abort_i),
    .fill_busy_o      (fill_busy_o),
    .fill_done_o      (fill_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string            tag;
    logic             v;
    logic [3:0][255:0] d;
  } exp_t;

  exp_t              sb[$];
  logic [255:0]      mem_m [4][64];
  logic [3:0][255:0] exp_rd;
  int                total = 0;
  int                bad   = 0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {255'b0, obs}, {255'b0, exp});
  endtask

  task automatic rd_issue(input logic [3:0] req, input logic [5:0] addr, input string tag,
                          input bit ov_en, input int ov_way, input logic [255:0] ov_line);
    exp_t e;
    rd_req_i  = req;
    rd_addr_i = addr;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) exp_rd[i] = (ov_en && i == ov_way) ? ov_line : mem_m[i][addr];
    end
    e.tag = tag;
    e.v   = |req;
    e.d   = exp_rd;
    sb.push_back(e);
  endtask

  task automatic rd_check();
    exp_t e;
    rd_req_i = 4'b0000;
    if (sb.size() == 0) begin
      chk1("scoreboard_underflow", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk1({e.tag, "_valid"}, rd_valid_o, e.v);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_way%0d", e.tag, i), rd_data_way_o[i], e.d[i]);
    end
  endtask

  task automatic fill_line(input int way, input int set, input logic [255:0] line, input int gap,
                           input bit col, input bit poke, input string tag);
    fill_start_i = 1'b1;
    fill_way_i   = 2'(way);
    fill_addr_i  = 6'(set);
    step();
    fill_start_i = 1'b0;
    chk1({tag, "_busy"}, fill_busy_o, 1'b1);
    chk1({tag, "_ready"}, fill_beat_ready_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        for (int g = 0; g < gap; g++) begin
          fill_beat_valid_i = 1'b0;
          step();
          chk1({tag, "_gap_ready"}, fill_beat_ready_o, 1'b1);
          chk1({tag, "_gap_done"}, fill_done_o, 1'b0);
        end
      end
      fill_beat_valid_i = 1'b1;
      fill_beat_i       = line[k*64 +: 64];
      step();
      if (k < 3) chk1({tag, "_early_done"}, fill_done_o, 1'b0);
    end
    fill_beat_valid_i = 1'b0;
    chk1({tag, "_done"}, fill_done_o, 1'b1);
    chk1({tag, "_write_ready"}, fill_beat_ready_o, 1'b0);
    if (col) rd_issue(4'b1111, 6'(set), {tag, "_collide"}, 1'b1, way, line);
    if (poke) begin
      fill_start_i = 1'b1;
      fill_abort_i = 1'b1;
      fill_way_i   = 2'(way + 1);
    end
    step();
    fill_start_i = 1'b0;
    fill_abort_i = 1'b0;
    chk1({tag, "_done_end"}, fill_done_o, 1'b0);
    chk1({tag, "_idle"}, fill_busy_o, 1'b0);
    if (col) rd_check();
    mem_m[way][set] = line;
  endtask

  logic [255:0] l1, l3, line;

  initial begin
    rstn_i = 1'b0; rd_req_i = '0; rd_addr_i = '0; fill_start_i = 1'b0; fill_way_i = '0;
    fill_addr_i = '0; fill_beat_valid_i = 1'b0; fill_beat_i = '0; fill_abort_i = 1'b0;
    exp_rd = '0;
    l1 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    l3 = {{8{8'h88}}, {8{8'h77}}, {8{8'h66}}, {8{8'h55}}};
    step(); step();
    chk1("rst_valid", rd_valid_o, 1'b0);
    chk1("rst_ready", fill_beat_ready_o, 1'b0);
    chk1("rst_busy", fill_busy_o, 1'b0);
    chk1("rst_done", fill_done_o, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_data%0d", i), rd_data_way_o[i], '0);
    rstn_i = 1'b1;
    step();

    for (int w = 0; w < 4; w++) begin
      for (int si = 0; si < 2; si++) begin
        line = {8{8'(w), 8'(si * 5), 16'hA5C3}};
        fill_line(w, si * 5, line, 0, 1'b0, 1'b0, "preload");
      end
    end

    fill_abort_i = 1'b1;
    step();
    fill_abort_i = 1'b0;
    chk1("abort_idle_busy", fill_busy_o, 1'b0);

    fill_line(2, 5, l1, 0, 1'b0, 1'b0, "fill_basic");
    rd_issue(4'b0100, 6'd5, "rd_basic", 1'b0, 0, '0);
    step();
    rd_check();

    fill_line(2, 5, l3, 0, 1'b1, 1'b1, "fill_col");
    rd_issue(4'b0100, 6'd5, "rd_after_col", 1'b0, 0, '0);
    step();
    rd_check();
    chk1("start_in_write_ignored", fill_busy_o, 1'b0);

    fill_line(2, 5, l1, 3, 1'b0, 1'b0, "fill_gap");
    rd_issue(4'b0100, 6'd5, "rd_gap", 1'b0, 0, '0);
    step();
    rd_check();

    fill_start_i = 1'b1; fill_way_i = 2'd1; fill_addr_i = 6'd0;
    step();
    fill_start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fill_beat_valid_i = 1'b1;
      fill_beat_i = 64'hBAD0_0000_0000_0000 | 64'(k);
      step();
    end
    fill_abort_i = 1'b1;
    fill_beat_i  = 64'hBAD0_FFFF_FFFF_FFFF;
    step();
    fill_abort_i = 1'b0;
    fill_beat_valid_i = 1'b0;
    chk1("abort_busy", fill_busy_o, 1'b0);
    chk1("abort_done", fill_done_o, 1'b0);
    chk1("abort_ready", fill_beat_ready_o, 1'b0);
    step();
    chk1("abort_done_later", fill_done_o, 1'b0);
    rd_issue(4'b0010, 6'd0, "rd_abort", 1'b0, 0, '0);
    step();
    rd_check();

    rd_issue(4'b1111, 6'd5, "rd_prereset", 1'b0, 0, '0);
    step();
    rd_check();
    fill_start_i = 1'b1; fill_way_i = 2'd3; fill_addr_i = 6'd5;
    step();
    fill_start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fill_beat_valid_i = 1'b1;
      fill_beat_i = 64'hDEAD_BEEF_0000_0000 | 64'(k);
      step();
    end
    chk1("pre_rst_busy", fill_busy_o, 1'b1);
    rstn_i = 1'b0;
    #1;
    chk1("arst_busy", fill_busy_o, 1'b0);
    chk1("arst_ready", fill_beat_ready_o, 1'b0);
    chk1("arst_done", fill_done_o, 1'b0);
    chk1("arst_valid", rd_valid_o, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("arst_data%0d", i), rd_data_way_o[i], '0);
    exp_rd = '0;
    fill_beat_valid_i = 1'b0;
    step();
    rstn_i = 1'b1;
    step();
    chk1("post_rst_busy", fill_busy_o, 1'b0);
    rd_issue(4'b1000, 6'd5, "rd_post_rst", 1'b0, 0, '0);
    step();
    rd_check();

    rd_issue(4'b0001, 6'd0, "rd_way0", 1'b0, 0, '0);
    step();
    rd_check();
    rd_issue(4'b0000, 6'd5, "rd_none", 1'b0, 0, '0);
    step();
    rd_check();

    chk("sb_empty", 256'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sargantana_idata_fill_memory.md
SARGANTANA_IDATA_FILL_MEMORY -- requirements
Module: sargantana_idata_fill_memory

Interface
REQ-001 Parameter ICACHE_N_WAY, default 4, number of ways.
REQ-002 Parameter SET_WIDHT, default 256, bits per line.
REQ-003 Parameter ADDR_WIDHT, default 6, set index width; depth = 2**ADDR_WIDHT.
REQ-004 Parameter BEAT_WIDTH, default 64, refill beat width; SET_WIDHT SHALL be an integer multiple of BEAT_WIDTH, with NBEATS = SET_WIDHT/BEAT_WIDTH >= 2.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low, ports clk_i and rstn_i.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rstn_i  in  1  asynchronous active-low reset.
REQ-008 rd_req_i  in  ICACHE_N_WAY  per-way read enable.
REQ-009 rd_addr_i  in  ADDR_WIDHT  read set index.
REQ-010 rd_valid_o  out  1  read data valid, one cycle after any rd_req_i bit.
REQ-011 rd_data_way_o  out  ICACHE_N_WAY x SET_WIDHT  registered line per way.
REQ-012 fill_start_i  in  1  begin a line refill.
REQ-013 fill_way_i  in  $clog2(ICACHE_N_WAY)  target way index, sampled with fill_start_i.
REQ-014 fill_addr_i  in  ADDR_WIDHT  target set, sampled with fill_start_i.
REQ-015 fill_beat_valid_i  in  1  refill beat valid.
REQ-016 fill_beat_i  in  BEAT_WIDTH  refill beat data.
REQ-017 fill_beat_ready_o  out  1  beat accept; a beat transfers when valid and ready are both high.
REQ-018 fill_abort_i  in  1  cancel the in-progress refill.
REQ-019 fill_busy_o  out  1  high whenever the FSM is not IDLE.
REQ-020 fill_done_o  out  1  high for exactly the WRITE cycle.

Function
REQ-021 The FSM SHALL have three states: IDLE, COLLECT and WRITE.
REQ-022 In IDLE, fill_start_i SHALL latch fill_way_i and fill_addr_i, clear the beat counter and move to COLLECT next cycle.
REQ-023 fill_start_i SHALL be ignored outside IDLE.
REQ-024 In COLLECT, fill_beat_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-025 Accepted beat k (k = 0 first) SHALL be stored at line bits [k*BEAT_WIDTH +: BEAT_WIDTH]; the beat counter SHALL increment per accepted beat and wrap to 0 after NBEATS-1.
REQ-026 Acceptance of beat NBEATS-1 SHALL move the FSM to WRITE; gaps (valid low) SHALL stall COLLECT indefinitely.
REQ-027 In WRITE, the assembled line SHALL be written to the latched way/set at the edge ending the cycle, then the FSM SHALL return to IDLE; a fill_start_i in WRITE is ignored.
REQ-028 fill_abort_i in COLLECT SHALL return the FSM to IDLE next cycle with no array write and no fill_done_o; any beat presented in that same cycle SHALL be discarded.
REQ-029 fill_abort_i SHALL be ignored in IDLE and WRITE.
REQ-030 A read SHALL have one-cycle latency: for each way i with rd_req_i[i]=1, rd_data_way_o[i] SHALL hold line (i, rd_addr_i) after the next edge.
REQ-031 rd_data_way_o[i] SHALL hold its previous value when rd_req_i[i]=0.
REQ-032 rd_valid_o SHALL be the registered OR of rd_req_i.
REQ-033 Read/write collision: a read in the WRITE cycle to the latched way and set SHALL return the newly written line (write-first); reads to other ways or sets SHALL return the old contents.
REQ-034 Reads SHALL never be stalled by fills, in any state.
REQ-035 Beat data SHALL not be visible to reads before WRITE.

Reset
REQ-036 On rstn_i low, the FSM SHALL go to IDLE and the beat counter SHALL clear, immediately and asynchronously.
REQ-037 Under reset, rd_valid_o, rd_data_way_o, fill_beat_ready_o, fill_busy_o and fill_done_o SHALL all be 0.
REQ-038 The array contents SHALL not be reset; a refill interrupted by reset SHALL leave the target line unmodified.

Verification
REQ-039 Refill way 2 set 5 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, no gaps -> fill_done_o high 5 cycles after start; read way 2 set 5 -> line equals 0x44..44_33..33_22..22_11..11 one cycle later, rd_valid_o=1.
REQ-040 Same refill with valid low for 3 cycles between beats 1 and 2 -> ready stays high, the correct line is written and fill_done_o fires 3 cycles later.
REQ-041 Abort after 2 beats into way 1 set 0, then read way 1 set 0 -> old contents, no fill_done_o.
REQ-042 Read rd_req_i=4'b1111 at set 5 in the WRITE cycle of a way 2 set 5 fill -> way 2 returns the new line, ways 0, 1 and 3 return their old lines.
REQ-043 Assert rstn_i mid-COLLECT -> all outputs 0 immediately; after release, fill_busy_o=0 and the target line is unchanged.
REQ-044 rd_req_i=4'b0001 followed by 4'b0000 -> only rd_data_way_o[0] updates; rd_valid_o pulses for one cycle; the other ways hold their values.
